bcd_chain_counter: RTL and testbench

Parametrised multi-digit BCD counter built from a chain of per-digit counters, each with its own modulus. Digits roll over in a mixed-radix way, so one block can hold plain decimal counts (all digits 0..9) or clock-style values such as mm:ss (digit limits 9,5,9,5). The block supports up/down counting, parallel load with clamping, synchronous clear, and a wrap or saturate policy. It is the counting core of the timer/stopwatch datapath: o_value drives the display decoders and o_carry cascades into further counters.

---
 rtl/bcd_chain_counter.sv | 85 ++++++++
 tb/tb_bcd_chain_counter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_chain_counter.sv
// Mixed-radix BCD counter: a chain of per-digit counters with individual limits.
// Supports up/down counting, clamped parallel load, sync clear, and wrap or saturate.
module bcd_chain_counter #(
  parameter int                  DIGITS    = 4,
  parameter logic [4*DIGITS-1:0] DIGIT_MAX = {DIGITS{4'h9}},
  parameter bit                  WRAP      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic [4*DIGITS-1:0]   i_init,
  input  logic                  i_init_vld,
  input  logic                  i_enable,
  input  logic                  i_count_down,
  output logic [4*DIGITS-1:0]   o_value,
  output logic                  o_carry,
  output logic                  o_wrap
);

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  function automatic logic [3:0] step_digit(input logic [3:0] d, input logic [3:0] lim,
                                            input logic down);
    if (down) return (d == 4'd0) ? lim : d - 4'd1;
    return (d >= lim) ? 4'd0 : d + 4'd1;
  endfunction

  logic [4*DIGITS-1:0] value_p1;
  logic                wrap_p1;
  logic [4*DIGITS-1:0] load_p0;
  logic [4*DIGITS-1:0] count_p0;
  logic [DIGITS-1:0]   at_bound_p0;
  logic [DIGITS-1:0]   en_p0;
  logic                all_bound_p0;
  logic                hold_p0;

  // Stage p0: boundary detect, enable ripple, candidate next values
  always_comb begin
    logic ripple;
    at_bound_p0 = '0;
    en_p0       = '0;
    load_p0     = '0;
    count_p0    = '0;
    ripple      = i_enable;
    for (int k = 0; k < DIGITS; k++) begin
      at_bound_p0[k] = i_count_down ? (value_p1[4*k +: 4] == 4'd0)
                                    : (value_p1[4*k +: 4] == DIGIT_MAX[4*k +: 4]);
      en_p0[k]       = ripple;
      ripple         = ripple & at_bound_p0[k];
      load_p0[4*k +: 4]  = clamp_digit(i_init[4*k +: 4], DIGIT_MAX[4*k +: 4]);
      count_p0[4*k +: 4] = en_p0[k] ? step_digit(value_p1[4*k +: 4], DIGIT_MAX[4*k +: 4],
                                                 i_count_down)
                                    : value_p1[4*k +: 4];
    end
  end

  assign all_bound_p0 = &at_bound_p0;
  // Saturating build freezes the whole value when the terminal count is reached
  assign hold_p0      = all_bound_p0 & (WRAP == 1'b0);

  // Stage p1: registered value and wrap pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_p1 <= '0;
      wrap_p1  <= 1'b0;
    end else begin
      wrap_p1 <= 1'b0;
      if (i_clear) begin
        value_p1 <= '0;
      end else if (i_init_vld) begin
        value_p1 <= load_p0;
      end else if (i_enable) begin
        if (!hold_p0) value_p1 <= count_p0;
        wrap_p1 <= all_bound_p0 & WRAP;
      end
    end
  end

  assign o_value = value_p1;
  assign o_wrap  = wrap_p1;
  assign o_carry = i_enable & all_bound_p0;

endmodule

// File: tb/tb_bcd_chain_counter.sv
// Bench for bcd_chain_counter: directed scenarios plus randomized traffic checked
// against a mixed-radix integer model of each instance.
module tb_bcd_chain_counter;

  localparam logic [15:0] MX_DEC = 16'h9999;
  localparam logic [15:0] MX_MM  = 16'h5959;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear, init_vld, enable, count_down, b_clear;
  logic [15:0] init;
  logic [15:0] val_dec, val_mm, val_sat, val_b;
  logic        carry_dec, carry_mm, carry_sat, carry_b;
  logic        wrap_dec, wrap_mm, wrap_sat, wrap_b;

  int n_tests = 0;
  int n_fail  = 0;

  int n_dec, n_mm, n_sat, n_b;
  bit w_dec, w_mm, w_sat, w_b;

  always #5 clk = ~clk;

  bcd_chain_counter #(.DIGITS(4), .DIGIT_MAX(MX_DEC), .WRAP(1'b1)) u_dec (
    .clk(clk), .rst_n(rst_n), .i_clear(clear), .i_init(init), .i_init_vld(init_vld),
    .i_enable(enable), .i_count_down(count_down),
    .o_value(val_dec), .o_carry(carry_dec), .o_wrap(wrap_dec));

  bcd_chain_counter #(.DIGITS(4), .DIGIT_MAX(MX_MM), .WRAP(1'b1)) u_mm (
    .clk(clk), .rst_n(rst_n), .i_clear(clear), .i_init(init), .i_init_vld(init_vld),
    .i_enable(enable), .i_count_down(count_down),
    .o_value(val_mm), .o_carry(carry_mm), .o_wrap(wrap_mm));

  bcd_chain_counter #(.DIGITS(4), .DIGIT_MAX(MX_DEC), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst_n(rst_n), .i_clear(clear), .i_init(init), .i_init_vld(init_vld),
    .i_enable(enable), .i_count_down(count_down),
    .o_value(val_sat), .o_carry(carry_sat), .o_wrap(wrap_sat));

  bcd_chain_counter #(.DIGITS(4), .DIGIT_MAX(MX_DEC), .WRAP(1'b1)) u_casc (
    .clk(clk), .rst_n(rst_n), .i_clear(b_clear), .i_init(16'h0000), .i_init_vld(1'b0),
    .i_enable(carry_dec), .i_count_down(1'b0),
    .o_value(val_b), .o_carry(carry_b), .o_wrap(wrap_b));

  // ---------------- reference model: value as a mixed-radix integer ----------------
  function automatic int total(input logic [15:0] mx);
    int t;
    t = 1;
    for (int k = 0; k < 4; k++) t = t * (int'(mx[4*k +: 4]) + 1);
    return t;
  endfunction

  function automatic int to_int(input logic [15:0] v, input logic [15:0] mx);
    int n, w;
    n = 0; w = 1;
    for (int k = 0; k < 4; k++) begin
      n = n + int'(v[4*k +: 4]) * w;
      w = w * (int'(mx[4*k +: 4]) + 1);
    end
    return n;
  endfunction

  function automatic logic [15:0] to_bcd(input int n, input logic [15:0] mx);
    logic [15:0] v;
    int r;
    v = '0; r = n;
    for (int k = 0; k < 4; k++) begin
      v[4*k +: 4] = 4'(r % (int'(mx[4*k +: 4]) + 1));
      r = r / (int'(mx[4*k +: 4]) + 1);
    end
    return v;
  endfunction

  function automatic logic [15:0] clamp(input logic [15:0] v, input logic [15:0] mx);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 4; k++)
      r[4*k +: 4] = (v[4*k +: 4] > mx[4*k +: 4]) ? mx[4*k +: 4] : v[4*k +: 4];
    return r;
  endfunction

  function automatic bit bound(input int n, input logic [15:0] mx, input bit dn);
    return dn ? (n == 0) : (n == total(mx) - 1);
  endfunction

  function automatic bit carry_of(input int n, input logic [15:0] mx, input bit en, input bit dn);
    return en && bound(n, mx, dn);
  endfunction

  function automatic int next_n(input int n, input logic [15:0] mx, input bit wrp, input bit clr,
                                input bit ldv, input logic [15:0] ini, input bit en, input bit dn);
    int t;
    t = total(mx);
    if (clr) return 0;
    if (ldv) return to_int(clamp(ini, mx), mx);
    if (!en) return n;
    if (!dn) return (n == t - 1) ? (wrp ? 0 : n) : n + 1;
    return (n == 0) ? (wrp ? t - 1 : 0) : n - 1;
  endfunction

  function automatic bit wrap_of(input int n, input logic [15:0] mx, input bit wrp, input bit clr,
                                 input bit ldv, input bit en, input bit dn);
    return !clr && !ldv && en && wrp && bound(n, mx, dn);
  endfunction

  task automatic model_reset();
    n_dec = 0; n_mm = 0; n_sat = 0; n_b = 0;
    w_dec = 0; w_mm = 0; w_sat = 0; w_b = 0;
  endtask

  // Advance one clock with the currently driven inputs and update the model.
  task automatic tick();
    int nd, nm, ns, nb;
    bit wd, wm, ws, wb, cd;
    cd = carry_of(n_dec, MX_DEC, enable, count_down);
    nd = next_n(n_dec, MX_DEC, 1, clear, init_vld, init, enable, count_down);
    nm = next_n(n_mm,  MX_MM,  1, clear, init_vld, init, enable, count_down);
    ns = next_n(n_sat, MX_DEC, 0, clear, init_vld, init, enable, count_down);
    nb = next_n(n_b,   MX_DEC, 1, b_clear, 0, 16'h0000, cd, 0);
    wd = wrap_of(n_dec, MX_DEC, 1, clear, init_vld, enable, count_down);
    wm = wrap_of(n_mm,  MX_MM,  1, clear, init_vld, enable, count_down);
    ws = wrap_of(n_sat, MX_DEC, 0, clear, init_vld, enable, count_down);
    wb = wrap_of(n_b,   MX_DEC, 1, b_clear, 0, cd, 0);
    @(posedge clk);
    #1;
    n_dec = nd; n_mm = nm; n_sat = ns; n_b = nb;
    w_dec = wd; w_mm = wm; w_sat = ws; w_b = wb;
  endtask

  task automatic drive(input bit clr, input bit ldv, input logic [15:0] ini,
                       input bit en, input bit dn);
    clear = clr; init_vld = ldv; init = ini; enable = en; count_down = dn;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; b_clear = 1'b0;
    drive(0, 0, 16'h0000, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_tests++;
    if (val_dec !== 16'h0000) begin n_fail++; $display("FAIL reset_value got %h exp 0000", val_dec); end
    n_tests++;
    if (wrap_dec !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got %b exp 0", wrap_dec); end
    n_tests++;
    if (carry_dec !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b exp 0", carry_dec); end
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      logic [15:0] e;
      e = 16'(i);
      tick();
      n_tests++;
      if (val_dec !== e) begin n_fail++; $display("FAIL reset_count%0d got %h exp %h", i, val_dec, e); end
    end
  endtask

  task automatic test_mixed_radix();
    drive(0, 1, 16'h0958, 0, 0);
    tick();
    n_tests++;
    if (val_mm !== 16'h0958) begin n_fail++; $display("FAIL mr_load got %h exp 0958", val_mm); end
    drive(0, 0, 16'h0000, 1, 0);
    n_tests++;
    if (carry_mm !== 1'b0) begin n_fail++; $display("FAIL mr_carry0 got %b exp 0", carry_mm); end
    tick();
    n_tests++;
    if (val_mm !== 16'h0959) begin n_fail++; $display("FAIL mr_step1 got %h exp 0959", val_mm); end
    n_tests++;
    if (carry_mm !== 1'b0) begin n_fail++; $display("FAIL mr_carry1 got %b exp 0", carry_mm); end
    tick();
    n_tests++;
    if (val_mm !== 16'h1000) begin n_fail++; $display("FAIL mr_step2 got %h exp 1000", val_mm); end
  endtask

  task automatic test_wrap();
    drive(0, 1, 16'h5959, 0, 0);
    tick();
    drive(0, 0, 16'h0000, 1, 0);
    n_tests++;
    if (carry_mm !== 1'b1) begin n_fail++; $display("FAIL wrap_up_carry got %b exp 1", carry_mm); end
    tick();
    n_tests++;
    if (val_mm !== 16'h0000) begin n_fail++; $display("FAIL wrap_up_value got %h exp 0000", val_mm); end
    n_tests++;
    if (wrap_mm !== 1'b1) begin n_fail++; $display("FAIL wrap_up_pulse got %b exp 1", wrap_mm); end
    drive(0, 0, 16'h0000, 0, 0);
    tick();
    n_tests++;
    if (wrap_mm !== 1'b0) begin n_fail++; $display("FAIL wrap_pulse_len got %b exp 0", wrap_mm); end
    drive(0, 1, 16'h0000, 0, 0);
    tick();
    n_tests++;
    if (wrap_mm !== 1'b0) begin n_fail++; $display("FAIL wrap_on_load got %b exp 0", wrap_mm); end
    drive(0, 0, 16'h0000, 1, 1);
    tick();
    n_tests++;
    if (val_mm !== 16'h5959) begin n_fail++; $display("FAIL wrap_dn_value got %h exp 5959", val_mm); end
    n_tests++;
    if (wrap_mm !== 1'b1) begin n_fail++; $display("FAIL wrap_dn_pulse got %b exp 1", wrap_mm); end
  endtask

  task automatic test_saturate();
    drive(0, 1, 16'h0000, 0, 0);
    tick();
    drive(0, 0, 16'h0000, 1, 1);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (carry_sat !== 1'b1) begin n_fail++; $display("FAIL sat_carry%0d got %b exp 1", i, carry_sat); end
      tick();
      n_tests++;
      if (val_sat !== 16'h0000) begin n_fail++; $display("FAIL sat_hold%0d got %h exp 0000", i, val_sat); end
      n_tests++;
      if (wrap_sat !== 1'b0) begin n_fail++; $display("FAIL sat_wrap%0d got %b exp 0", i, wrap_sat); end
    end
    drive(0, 0, 16'h0000, 1, 0);
    tick();
    n_tests++;
    if (val_sat !== 16'h0001) begin n_fail++; $display("FAIL sat_away got %h exp 0001", val_sat); end
  endtask

  task automatic test_clamp_priority();
    drive(0, 1, 16'h7A99, 0, 0);
    tick();
    n_tests++;
    if (val_mm !== 16'h5959) begin n_fail++; $display("FAIL clamp_mm got %h exp 5959", val_mm); end
    n_tests++;
    if (val_dec !== 16'h7999) begin n_fail++; $display("FAIL clamp_dec got %h exp 7999", val_dec); end
    drive(1, 1, 16'h1234, 1, 0);
    n_tests++;
    if (carry_mm !== 1'b1) begin n_fail++; $display("FAIL carry_unmasked got %b exp 1", carry_mm); end
    tick();
    n_tests++;
    if (val_mm !== 16'h0000) begin n_fail++; $display("FAIL prio_clear got %h exp 0000", val_mm); end
    n_tests++;
    if (wrap_mm !== 1'b0) begin n_fail++; $display("FAIL prio_clear_wrap got %b exp 0", wrap_mm); end
    drive(0, 1, 16'h1234, 1, 0);
    tick();
    n_tests++;
    if (val_mm !== 16'h1234) begin n_fail++; $display("FAIL prio_load got %h exp 1234", val_mm); end
  endtask

  task automatic test_cascade();
    b_clear = 1'b1;
    drive(0, 1, 16'h9999, 0, 0);
    tick();
    b_clear = 1'b0;
    drive(0, 0, 16'h0000, 1, 0);
    n_tests++;
    if (carry_dec !== 1'b1) begin n_fail++; $display("FAIL casc_carry got %b exp 1", carry_dec); end
    tick();
    n_tests++;
    if (val_dec !== 16'h0000) begin n_fail++; $display("FAIL casc_a got %h exp 0000", val_dec); end
    n_tests++;
    if (val_b !== 16'h0001) begin n_fail++; $display("FAIL casc_b got %h exp 0001", val_b); end
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (val_dec !== 16'h0000) begin n_fail++; $display("FAIL async_a got %h exp 0000", val_dec); end
    n_tests++;
    if (val_b !== 16'h0000) begin n_fail++; $display("FAIL async_b got %h exp 0000", val_b); end
    #2;
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (val_dec !== 16'h0001) begin n_fail++; $display("FAIL post_reset got %h exp 0001", val_dec); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ri;
      ri = 16'($urandom);
      // bias loads toward all-nines / all-zeros so boundaries get exercised
      if ($urandom_range(0, 3) == 0) ri = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h0000;
      b_clear = ($urandom_range(0, 31) == 0);
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, ri,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      n_tests++;
      if (carry_dec !== carry_of(n_dec, MX_DEC, enable, count_down)) begin
        n_fail++; $display("FAIL rnd%0d carry_dec got %b", i, carry_dec); end
      n_tests++;
      if (carry_mm !== carry_of(n_mm, MX_MM, enable, count_down)) begin
        n_fail++; $display("FAIL rnd%0d carry_mm got %b", i, carry_mm); end
      n_tests++;
      if (carry_sat !== carry_of(n_sat, MX_DEC, enable, count_down)) begin
        n_fail++; $display("FAIL rnd%0d carry_sat got %b", i, carry_sat); end
      tick();
      n_tests++;
      if (val_dec !== to_bcd(n_dec, MX_DEC)) begin
        n_fail++; $display("FAIL rnd%0d val_dec got %h exp %h", i, val_dec, to_bcd(n_dec, MX_DEC)); end
      n_tests++;
      if (val_mm !== to_bcd(n_mm, MX_MM)) begin
        n_fail++; $display("FAIL rnd%0d val_mm got %h exp %h", i, val_mm, to_bcd(n_mm, MX_MM)); end
      n_tests++;
      if (val_sat !== to_bcd(n_sat, MX_DEC)) begin
        n_fail++; $display("FAIL rnd%0d val_sat got %h exp %h", i, val_sat, to_bcd(n_sat, MX_DEC)); end
      n_tests++;
      if (val_b !== to_bcd(n_b, MX_DEC)) begin
        n_fail++; $display("FAIL rnd%0d val_b got %h exp %h", i, val_b, to_bcd(n_b, MX_DEC)); end
      n_tests++;
      if ({wrap_dec, wrap_mm, wrap_sat, wrap_b} !== {w_dec, w_mm, w_sat, w_b}) begin
        n_fail++; $display("FAIL rnd%0d wraps got %b exp %b", i,
                           {wrap_dec, wrap_mm, wrap_sat, wrap_b}, {w_dec, w_mm, w_sat, w_b}); end
    end
  endtask

  initial begin
    test_reset();
    test_mixed_radix();
    test_wrap();
    test_saturate();
    test_clamp_priority();
    test_cascade();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
